// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: one-hot states,
// parameter-register addresses and the per-state switch vector.
package pulse_seq_pkg;

  localparam int I_IDLE  = 0;
  localparam int I_INIT  = 1;
  localparam int I_CFG   = 2;
  localparam int I_START = 3;
  localparam int I_PULSE = 4;
  localparam int I_DUMP  = 5;
  localparam int I_STOP  = 6;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_INIT  = 7'b0000010,
    S_CFG   = 7'b0000100,
    S_START = 7'b0001000,
    S_PULSE = 7'b0010000,
    S_DUMP  = 7'b0100000,
    S_STOP  = 7'b1000000
  } state_t;

  localparam logic [1:0] A_PLUSE = 2'd0;
  localparam logic [1:0] A_DUMP  = 2'd1;
  localparam logic [1:0] A_ECHO  = 2'd2;

  // {soft_d, rt_sw, sw_acq1, sw_acq2, pluse_acq, dds_config, pluse_start, dump_start}
  function automatic logic [7:0] out_vec(input state_t s);
    logic [7:0] v;
    v = 8'b0011_0000;
    case (s)
      S_CFG:   v = 8'b0001_0000;
      S_START: v = 8'b1001_1101;
      S_PULSE: v = 8'b1001_1010;
      S_DUMP:  v = 8'b1001_1001;
      default: v = 8'b0011_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable phase down-counter; a zero duration is clamped to one tick.
// Holds at 1 so an idle phase never wraps.
module seq_timer #(
  parameter int TW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic          load,
  input  logic [TW-1:0] dur,
  output logic [TW-1:0] count,
  output logic          expire
);

  assign expire = clken && (count == TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= TW'(1);
    end else if (load) begin
      count <= (dur == '0) ? TW'(1) : dur;
    end else if (clken && (count > TW'(1))) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer: INIT, CONFIG, START, then PULSE/DUMP per echo, STOP.
// Outputs are registered from the next state so they switch with it.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int TW         = 20,
  parameter int EW         = 12,
  parameter int INIT_TIME  = 100,
  parameter int CFG_TIME   = 400,
  parameter int START_TIME = 30
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          clken_p,
  input  logic          start,
  input  logic          abort,
  input  logic          load,
  input  logic [1:0]    load_addr,
  input  logic [TW-1:0] datain,
  output logic          soft_d,
  output logic          rt_sw,
  output logic          sw_acq1,
  output logic          sw_acq2,
  output logic          pluse_acq,
  output logic          dds_config,
  output logic          pluse_start,
  output logic          dump_start,
  output logic          busy,
  output logic          done,
  output logic          state_over_n,
  output logic [TW-1:0] timecount,
  output logic [EW-1:0] echo_cnt
);

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] plusetime;
  logic [TW-1:0] dumptime;
  logic [TW-1:0] dur;
  logic [EW-1:0] echo_num;
  logic [EW:0]   echo_lim;
  logic [EW:0]   echo_nxt;
  logic          expire;
  logic          go;
  logic          more;
  logic          tload;

  assign go       = state[I_IDLE] && start && !abort;
  assign echo_lim = (echo_num == '0) ? (EW+1)'(1) : {1'b0, echo_num};
  assign echo_nxt = {1'b0, echo_cnt} + (EW+1)'(1);
  assign more     = echo_nxt < echo_lim;
  assign tload    = (nxt != state);

  always_comb begin
    nxt = state;
    if (state[I_STOP]) begin
      nxt = S_IDLE;
    end else if (state[I_IDLE]) begin
      if (go) nxt = S_INIT;
    end else if (abort) begin
      nxt = S_STOP;
    end else if (expire) begin
      unique case (1'b1)
        state[I_INIT]:  nxt = S_CFG;
        state[I_CFG]:   nxt = S_START;
        state[I_START]: nxt = S_PULSE;
        state[I_PULSE]: nxt = S_DUMP;
        state[I_DUMP]:  nxt = more ? S_PULSE : S_STOP;
        default:        nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dur = TW'(1);
    unique case (1'b1)
      nxt[I_INIT]:  dur = TW'(INIT_TIME);
      nxt[I_CFG]:   dur = TW'(CFG_TIME);
      nxt[I_START]: dur = TW'(START_TIME);
      nxt[I_PULSE]: dur = plusetime;
      nxt[I_DUMP]:  dur = dumptime;
      default:      dur = TW'(1);
    endcase
  end

  seq_timer #(.TW(TW)) u_timer (
    .clk    (clk_sys),
    .rst    (rst),
    .clken  (clken_p),
    .load   (tload),
    .dur    (dur),
    .count  (timecount),
    .expire (expire)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      {soft_d, rt_sw, sw_acq1, sw_acq2,
       pluse_acq, dds_config, pluse_start,
       dump_start} <= out_vec(S_IDLE);
      busy         <= 1'b0;
      done         <= 1'b0;
      state_over_n <= 1'b1;
      echo_cnt     <= '0;
      plusetime    <= TW'(1);
      dumptime     <= TW'(1);
      echo_num     <= EW'(1);
    end else begin
      state        <= nxt;
      {soft_d, rt_sw, sw_acq1, sw_acq2,
       pluse_acq, dds_config, pluse_start,
       dump_start} <= out_vec(nxt);
      busy         <= !nxt[I_IDLE];
      done         <= nxt[I_STOP];
      if (go)
        state_over_n <= 1'b1;
      else if (nxt[I_STOP])
        state_over_n <= 1'b0;
      // An aborted DUMP does not count as a completed echo.
      if (go)
        echo_cnt <= '0;
      else if (state[I_DUMP] && expire && !abort)
        echo_cnt <= echo_cnt + EW'(1);
      if (load && !busy) begin
        case (load_addr)
          A_PLUSE: plusetime <= datain;
          A_DUMP:  dumptime  <= datain;
          A_ECHO:  echo_num  <= datain[EW-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scenario bench for pulse_seq_ctrl; random runs are checked
// against a phase-list model indexed by elapsed ticks.
module tb_pulse_seq_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        clken_p = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  load_addr = 2'd0;
  logic [19:0] datain = '0;
  logic        soft_d, rt_sw, sw_acq1, sw_acq2;
  logic        pluse_acq, dds_config, pluse_start, dump_start;
  logic        busy, done, state_over_n;
  logic [19:0] timecount;
  logic [11:0] echo_cnt;
  logic [7:0]  vec;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] IDLE_V = 8'b0011_0000;
  localparam logic [7:0] VTAB [5] = '{
    8'b0011_0000, 8'b0001_0000, 8'b1001_1101,
    8'b1001_1010, 8'b1001_1001
  };

  int m_plens[$];
  int m_dlens[$];
  int m_dcyc;
  int m_dones;
  int m_echo;

  pulse_seq_ctrl dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .clken_p      (clken_p),
    .start        (start),
    .abort        (abort),
    .load         (load),
    .load_addr    (load_addr),
    .datain       (datain),
    .soft_d       (soft_d),
    .rt_sw        (rt_sw),
    .sw_acq1      (sw_acq1),
    .sw_acq2      (sw_acq2),
    .pluse_acq    (pluse_acq),
    .dds_config   (dds_config),
    .pluse_start  (pluse_start),
    .dump_start   (dump_start),
    .busy         (busy),
    .done         (done),
    .state_over_n (state_over_n),
    .timecount    (timecount),
    .echo_cnt     (echo_cnt)
  );

  assign vec = {soft_d, rt_sw, sw_acq1, sw_acq2,
                pluse_acq, dds_config, pluse_start, dump_start};

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_load(input logic [1:0] a, input int v);
    load = 1'b1;
    load_addr = a;
    datain = 20'(v);
    clken_p = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Runs one sequence from IDLE and records run lengths of
  // pluse_start / dump_start, the done cycle and final echo count.
  task automatic measure(input int mode);
    int  n;
    logic pp;
    logic pd;
    m_plens = {};
    m_dlens = {};
    m_dcyc = -1;
    m_dones = 0;
    pp = 1'b0;
    pd = 1'b0;
    start = 1'b1;
    clken_p = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 20000) begin
      clken_p = (mode == 0) || (n % 4 == 0);
      tick();
      if (pluse_start) begin
        if (!pp) m_plens.push_back(1);
        else m_plens[m_plens.size()-1] += 1;
      end
      if (dump_start) begin
        if (!pd) m_dlens.push_back(1);
        else m_dlens[m_dlens.size()-1] += 1;
      end
      pp = pluse_start;
      pd = dump_start;
      if (done) begin
        m_dones++;
        if (m_dcyc < 0) m_dcyc = n;
      end
      if (!busy) break;
      n++;
    end
    m_echo = int'(echo_cnt);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL measure_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if (vec !== IDLE_V || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs vec=%b busy=%b done=%b required %b 0 0",
               vec, busy, done, IDLE_V);
    end
    checks++;
    if (timecount !== 20'd1 || echo_cnt !== 12'd0 || state_over_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_regs tc=%0d echo=%0d over_n=%b required 1 0 1",
               timecount, echo_cnt, state_over_n);
    end
    rst = 1'b0;
    clken_p = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || timecount !== 20'd1) begin
      failures++;
      $display("FAIL reset_idle busy=%b tc=%0d required 0 1", busy, timecount);
    end
  endtask

  task automatic test_main();
    do_load(2'd0, 5);
    do_load(2'd1, 3);
    do_load(2'd2, 2);
    measure(0);
    checks++;
    if (m_plens.size() != 2 || m_plens[0] != 5 || m_plens[1] != 5) begin
      failures++;
      $display("FAIL main_pulse n=%0d first=%0d required 2 runs of 5",
               m_plens.size(), m_plens.size() > 0 ? m_plens[0] : -1);
    end
    checks++;
    if (m_dlens.size() != 3 || m_dlens[0] != 30 || m_dlens[1] != 3 || m_dlens[2] != 3) begin
      failures++;
      $display("FAIL main_dump n=%0d required runs 30,3,3", m_dlens.size());
    end
    checks++;
    if (m_dcyc != 546 || m_dones != 1) begin
      failures++;
      $display("FAIL main_done cyc=%0d cnt=%0d required 546 1", m_dcyc, m_dones);
    end
    checks++;
    if (m_echo != 2 || state_over_n !== 1'b0) begin
      failures++;
      $display("FAIL main_end echo=%0d over_n=%b required 2 0", m_echo, state_over_n);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || state_over_n !== 1'b0 || vec !== IDLE_V) begin
      failures++;
      $display("FAIL start_abort_idle busy=%b over_n=%b required 0 0",
               busy, state_over_n);
    end
  endtask

  task automatic test_quarter();
    do_load(2'd0, 2);
    do_load(2'd1, 1);
    do_load(2'd2, 1);
    measure(1);
    checks++;
    if (m_plens.size() != 1 || m_plens[0] != 8 || m_dones != 1) begin
      failures++;
      $display("FAIL quarter_pulse n=%0d len=%0d dones=%0d required 1 8 1",
               m_plens.size(), m_plens.size() > 0 ? m_plens[0] : -1, m_dones);
    end
  endtask

  task automatic test_zero();
    do_load(2'd0, 0);
    do_load(2'd1, 1);
    do_load(2'd2, 0);
    measure(0);
    checks++;
    if (m_plens.size() != 1 || m_plens[0] != 1 || m_echo != 1) begin
      failures++;
      $display("FAIL zero_dur n=%0d len=%0d echo=%0d required 1 1 1",
               m_plens.size(), m_plens.size() > 0 ? m_plens[0] : -1, m_echo);
    end
  endtask

  task automatic test_abort();
    int   np;
    int   n;
    logic prev;
    do_load(2'd0, 5);
    do_load(2'd1, 3);
    do_load(2'd2, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    np = 0;
    prev = 1'b0;
    n = 0;
    while (np < 2 && n < 2000) begin
      tick();
      if (pluse_start && !prev) np++;
      prev = pluse_start;
      n++;
    end
    checks++;
    if (np != 2) begin
      failures++;
      $display("FAIL abort_reach pulses=%0d required 2", np);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || state_over_n !== 1'b0 || vec !== IDLE_V || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_stop done=%b over_n=%b vec=%b busy=%b required 1 0 %b 1",
               done, state_over_n, vec, busy, IDLE_V);
    end
    checks++;
    if (echo_cnt !== 12'd1) begin
      failures++;
      $display("FAIL abort_echo echo=%0d required 1", echo_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_load_busy();
    do_load(2'd0, 4);
    do_load(2'd1, 1);
    do_load(2'd2, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL load_busy_state busy=%b required 1", busy);
    end
    do_load(2'd0, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    measure(0);
    checks++;
    if (m_plens.size() != 1 || m_plens[0] != 4) begin
      failures++;
      $display("FAIL load_busy_hold len=%0d required 4",
               m_plens.size() > 0 ? m_plens[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int p, d, e, ee, t, total, n, acc, kind, rem, ec;
      int durs[$];
      int kinds[$];
      p = $urandom_range(0, 6);
      d = $urandom_range(0, 4);
      e = $urandom_range(0, 3);
      do_load(2'd0, p);
      do_load(2'd1, d);
      do_load(2'd2, e);
      ee = (e == 0) ? 1 : e;
      durs = {100, 400, 30};
      kinds = {0, 1, 2};
      for (int k = 0; k < ee; k++) begin
        durs.push_back(p == 0 ? 1 : p);
        kinds.push_back(3);
        durs.push_back(d == 0 ? 1 : d);
        kinds.push_back(4);
      end
      total = 0;
      foreach (durs[k]) total += durs[k];
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      n = 0;
      while (1) begin
        if (t < total) begin
          acc = 0;
          kind = 0;
          rem = 0;
          ec = 0;
          foreach (durs[k]) begin
            if (t >= acc && t < acc + durs[k]) begin
              kind = kinds[k];
              rem = acc + durs[k] - t;
            end
            if (t >= acc + durs[k] && kinds[k] == 4) ec++;
            acc += durs[k];
          end
          checks++;
          if (vec !== VTAB[kind] || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL rand_vec t=%0d vec=%b busy=%b done=%b required %b 1 0",
                     t, vec, busy, done, VTAB[kind]);
          end
          checks++;
          if (timecount !== 20'(rem) || echo_cnt !== 12'(ec)) begin
            failures++;
            $display("FAIL rand_cnt t=%0d tc=%0d echo=%0d required %0d %0d",
                     t, timecount, echo_cnt, rem, ec);
          end
        end else begin
          checks++;
          if (done !== 1'b1 || busy !== 1'b1 || vec !== IDLE_V ||
              state_over_n !== 1'b0 || echo_cnt !== 12'(ee)) begin
            failures++;
            $display("FAIL rand_stop done=%b busy=%b vec=%b over_n=%b echo=%0d required 1 1 %b 0 %0d",
                     done, busy, vec, state_over_n, echo_cnt, IDLE_V, ee);
          end
          break;
        end
        n++;
        if (n > 5000) begin
          checks++;
          failures++;
          $display("FAIL rand_timeout t=%0d required %0d", t, total);
          break;
        end
        clken_p = (it % 2 == 1) ? 1'b1 : 1'($urandom % 2);
        start = ($urandom % 16 == 0);
        load = ($urandom % 8 == 0);
        load_addr = 2'($urandom);
        datain = 20'($urandom % 8);
        tick();
        t += int'(clken_p);
      end
      start = 1'b0;
      load = 1'b0;
      clken_p = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || state_over_n !== 1'b0 ||
          echo_cnt !== 12'(ee)) begin
        failures++;
        $display("FAIL rand_idle busy=%b done=%b over_n=%b echo=%0d required 0 0 0 %0d",
                 busy, done, state_over_n, echo_cnt, ee);
      end
    end
  endtask

  task automatic test_reset_dump();
    int n;
    int nd;
    do_load(2'd0, 3);
    do_load(2'd1, 6);
    do_load(2'd2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (vec !== VTAB[4] && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (vec !== VTAB[4]) begin
      failures++;
      $display("FAIL rstdump_reach vec=%b required %b", vec, VTAB[4]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (vec !== IDLE_V || busy !== 1'b0 || done !== 1'b0 || state_over_n !== 1'b1) begin
      failures++;
      $display("FAIL rstdump_async vec=%b busy=%b done=%b over_n=%b required %b 0 0 1",
               vec, busy, done, state_over_n, IDLE_V);
    end
    checks++;
    if (timecount !== 20'd1 || echo_cnt !== 12'd0) begin
      failures++;
      $display("FAIL rstdump_cnt tc=%0d echo=%0d required 1 0", timecount, echo_cnt);
    end
    tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL rstdump_nodone active_cycles=%0d required 0", nd);
    end
    measure(0);
    checks++;
    if (m_plens.size() != 1 || m_plens[0] != 1 || m_dlens.size() != 2 ||
        m_dlens[1] != 1 || m_echo != 1 || m_dcyc != 532) begin
      failures++;
      $display("FAIL rstdump_defaults pulses=%0d dumps=%0d echo=%0d done_cyc=%0d required 1 2 1 532",
               m_plens.size(), m_dlens.size(), m_echo, m_dcyc);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_start_abort_idle();
    test_quarter();
    test_zero();
    test_abort();
    test_load_busy();
    test_random();
    test_reset_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_seq_ctrl.md
PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TW, default 20, meaning timer and datain width.
REQ-002 The block SHALL have parameter EW, default 12, meaning echo counter width.
REQ-003 The block SHALL have parameters INIT_TIME, CFG_TIME and START_TIME, defaults 100, 400 and 30, meaning fixed phase durations in clken_p ticks.
REQ-004 The block SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port clken_p, input, 1 bit: timer tick enable.
REQ-007 The block SHALL have ports start and abort, inputs, 1 bit each: sequence request and sequence cancel.
REQ-008 The block SHALL have ports load (input, 1), load_addr (input, 2) and datain (input, TW): parameter write.
REQ-009 The block SHALL have outputs soft_d, rt_sw, sw_acq1, sw_acq2, pluse_acq, dds_config, pluse_start and dump_start, 1 bit each: switch and acquisition controls.
REQ-010 The block SHALL have outputs busy (1), done (1, one-cycle pulse) and state_over_n (1, active-low end flag).
REQ-011 The block SHALL have outputs timecount (TW), the remaining ticks in the current phase, and echo_cnt (EW), the count of completed echoes.

Function
REQ-012 When load=1 and busy=0, datain SHALL be written to the register selected by load_addr: 0 PLUSETIME, 1 DUMPTIME, 2 ECHO_NUM (low EW bits), 3 ignored.
REQ-013 When load=1 and busy=1, the write SHALL be ignored and all registers SHALL hold.
REQ-014 The states SHALL be IDLE, INIT, CONFIG, START, PULSE, DUMP and STOP, one-hot encoded.
REQ-015 From IDLE, start=1 SHALL move the block to INIT on the next clk_sys edge.
REQ-016 The phase sequence SHALL be INIT -> CONFIG -> START -> PULSE -> DUMP.
REQ-017 On entering a state, timecount SHALL load that state's duration: INIT_TIME, CFG_TIME, START_TIME, PLUSETIME or DUMPTIME respectively.
REQ-018 timecount SHALL decrement only on cycles with clken_p=1.
REQ-019 The state SHALL advance on the clken_p cycle in which timecount=1, so each phase lasts exactly its duration in ticks.
REQ-020 A programmed duration of 0 SHALL be treated as 1.
REQ-021 On leaving DUMP, echo_cnt SHALL increment; the next state SHALL be PULSE if echo_cnt+1 < ECHO_NUM, else STOP.
REQ-022 ECHO_NUM=0 SHALL be treated as 1.
REQ-023 STOP SHALL last exactly one clk_sys cycle, assert done for that cycle, then return to IDLE.
REQ-024 abort=1 in any state other than IDLE SHALL force STOP on the next edge, and done SHALL still pulse.
REQ-025 start and abort asserted together in IDLE: abort SHALL win and the block SHALL remain in IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 All outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state.
REQ-029 Output values per state SHALL be (soft_d, rt_sw, sw_acq1, sw_acq2, pluse_acq, dds_config, pluse_start, dump_start):
  IDLE/INIT/STOP = 0,0,1,1,0,0,0,0
  CONFIG = 0,0,0,1,0,0,0,0
  START = 1,0,0,1,1,1,0,1
  PULSE = 1,0,0,1,1,0,1,0
  DUMP = 1,0,0,1,1,0,0,1
REQ-030 state_over_n SHALL go to 0 on entry to STOP and SHALL stay 0 until the next accepted start, which SHALL return it to 1.
REQ-031 echo_cnt SHALL clear to 0 on an accepted start and SHALL hold its final value in IDLE.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, timecount=1, echo_cnt=0, busy=0, done=0, state_over_n=1 and the IDLE output vector.
REQ-033 The PLUSETIME, DUMPTIME and ECHO_NUM registers SHALL reset to 1.
REQ-034 Reset mid-sequence SHALL abandon the sequence without a done pulse.

Structure
REQ-035 Package pulse_seq_pkg SHALL hold the one-hot state constants and the load address constants.
REQ-036 One sub-module, seq_timer, SHALL implement the loadable TW-bit down-counter with clken_p and a zero-duration clamp.

Verification
REQ-037 Load 5 to PLUSETIME, 3 to DUMPTIME and 2 to ECHO_NUM; hold clken_p=1 and pulse start. Required: PULSE and DUMP alternate twice, pluse_start is high for 5 cycles each time, done pulses once 100+400+30+16 cycles after INIT entry, and echo_cnt ends at 2.
REQ-038 Drive clken_p at 1-in-4 with PLUSETIME=2. Required: PULSE lasts 8 clk_sys cycles.
REQ-039 Load PLUSETIME=0 and ECHO_NUM=0. Required: PULSE lasts 1 tick and there is a single echo.
REQ-040 Assert abort during the second PULSE. Required: STOP follows, done pulses, state_over_n=0 and all switch outputs return to the IDLE vector.
REQ-041 Write load_addr=0 with datain=7 while busy, then start a new sequence. Required: the old PLUSETIME is used.
REQ-042 Assert rst in DUMP. Required: outputs immediately take the IDLE vector and no done pulse occurs.
